multicycle_controller: RTL and testbench

- Multicycle successor to the single-cycle combinational controller of the 6-bit-opcode core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over several cycles.
- Handshakes with a variable-latency memory and tracks return-stack occupancy, raising a sticky fault on stack overflow/underflow, memory timeout or illegal opcode.
- Sits between the instruction register / flag register and the datapath select lines; decodes using the existing opcode/function defines (REGISTER_TYPE_OPCODE … OTHER_TYPE_OPCODE, STM_FN/LDM_FN, BZ/BC/BNZ/BNC_FN, JSB_OPCODE).

---
 rtl/multicycle_controller.sv | 275 +++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle controller for the 6-bit-opcode core.
// FETCH/DECODE/EXEC/MEM/WB sequencer with return-stack tracking.
//
// Ports:
//   clk, rst (async, active high)
//   instr_valid, instruction[5:0] : instruction memory side
//   c, z : flags, latched in DECODE
//   mem_ready : data memory completes this cycle
//   ir_load, pc_write, ALU_op, sel_* : datapath controls
//   MemRead, MemWrite, RegisterFileWriteEn : strobes
//   push_stack, pop_stack, stack_count : return stack
//   fault (sticky), busy (not FETCH/FAULT)
//
// Opcode map:
//   00_xxx_x register  01_xxx_x immediate  1000_xx shift
//   1001_00 LDM  1001_01 STM  1010_ff conditional jump
//   1011_00 JMP  1011_01 JSB  110000 RET
//   anything else is illegal
module multicycle_controller #(
  parameter int STACK_DEPTH = 8,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [5:0]       instruction,
  input  logic             c,
  input  logic             z,
  input  logic             mem_ready,
  output logic             ir_load,
  output logic             pc_write,
  output logic [3:0]       ALU_op,
  output logic             sel_ALUScr_reg,
  output logic             sel_ALUScr_const,
  output logic             sel_PCSrc_plus1,
  output logic             sel_PCSrc_offset,
  output logic             sel_PCSrc_const,
  output logic             sel_PCSrc_stack,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegisterFileWriteEn,
  output logic             sel_RegisterFile_in_alu,
  output logic             sel_RegisterFile_in_memory,
  output logic             sel_RegisterFile_in_shifter,
  output logic             sel_RegisterFileReadReg2_rd,
  output logic             sel_Cin_alu,
  output logic             sel_Cin_shifter,
  output logic             push_stack,
  output logic             pop_stack,
  output logic [CNT_W-1:0] stack_count,
  output logic             fault,
  output logic             busy
);

  localparam logic [1:0] REGISTER_TYPE_OPCODE  = 2'b00;
  localparam logic [1:0] IMMEDIATE_TYPE_OPCODE = 2'b01;
  localparam logic [3:0] SHIFT_TYPE_OPCODE     = 4'b1000;
  localparam logic [3:0] MEMORY_TYPE_OPCODE    = 4'b1001;
  localparam logic [3:0] COND_JUMP_OPCODE      = 4'b1010;
  localparam logic [3:0] JUMP_TYPE_OPCODE      = 4'b1011;
  localparam logic [1:0] LDM_FN = 2'b00;
  localparam logic [1:0] STM_FN = 2'b01;
  localparam logic [1:0] BZ_FN  = 2'b00;
  localparam logic [1:0] BNZ_FN = 2'b01;
  localparam logic [1:0] BC_FN  = 2'b10;
  localparam logic [1:0] BNC_FN = 2'b11;
  localparam logic [1:0] JMP_FN = 2'b00;
  localparam logic [5:0] JSB_OPCODE        = 6'b101101;
  localparam logic [5:0] OTHER_TYPE_OPCODE = 6'b110000;
  localparam logic [3:0] ADD_SIGNED = 4'b1000;

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       instr_q, instr_d;
  logic             c_q, c_d, z_q, z_d;
  logic [CNT_W-1:0] stack_count_q, stack_count_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic is_reg, is_imm, is_shift, is_ldm, is_stm;
  logic is_bcond, is_jmp, is_jsb, is_ret, is_legal;
  logic taken;

  assign is_reg   = instr_q[5:4] == REGISTER_TYPE_OPCODE;
  assign is_imm   = instr_q[5:4] == IMMEDIATE_TYPE_OPCODE;
  assign is_shift = instr_q[5:2] == SHIFT_TYPE_OPCODE;
  assign is_ldm   = instr_q == {MEMORY_TYPE_OPCODE, LDM_FN};
  assign is_stm   = instr_q == {MEMORY_TYPE_OPCODE, STM_FN};
  assign is_bcond = instr_q[5:2] == COND_JUMP_OPCODE;
  assign is_jmp   = instr_q == {JUMP_TYPE_OPCODE, JMP_FN};
  assign is_jsb   = instr_q == JSB_OPCODE;
  assign is_ret   = instr_q == OTHER_TYPE_OPCODE;
  assign is_legal = is_reg | is_imm | is_shift | is_ldm | is_stm
                  | is_bcond | is_jmp | is_jsb | is_ret;

  always_comb begin
    taken = 1'b0;
    unique case (instr_q[1:0])
      BZ_FN:   taken = z_q;
      BNZ_FN:  taken = ~z_q;
      BC_FN:   taken = c_q;
      BNC_FN:  taken = ~c_q;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FETCH;
      instr_q       <= '0;
      c_q           <= 1'b0;
      z_q           <= 1'b0;
      stack_count_q <= '0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      c_q           <= c_d;
      z_q           <= z_d;
      stack_count_q <= stack_count_d;
      tmo_q         <= tmo_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    c_d           = c_q;
    z_d           = z_q;
    stack_count_d = stack_count_q;
    tmo_d         = tmo_q;

    ir_load                     = 1'b0;
    pc_write                    = 1'b0;
    ALU_op                      = 4'b0000;
    sel_ALUScr_reg              = 1'b0;
    sel_ALUScr_const            = 1'b0;
    sel_PCSrc_plus1             = 1'b0;
    sel_PCSrc_offset            = 1'b0;
    sel_PCSrc_const             = 1'b0;
    sel_PCSrc_stack             = 1'b0;
    MemRead                     = 1'b0;
    MemWrite                    = 1'b0;
    RegisterFileWriteEn         = 1'b0;
    sel_RegisterFile_in_alu     = 1'b0;
    sel_RegisterFile_in_memory  = 1'b0;
    sel_RegisterFile_in_shifter = 1'b0;
    sel_RegisterFileReadReg2_rd = 1'b0;
    sel_Cin_alu                 = 1'b0;
    sel_Cin_shifter             = 1'b0;
    push_stack                  = 1'b0;
    pop_stack                   = 1'b0;
    fault                       = 1'b0;
    busy                        = 1'b1;

    unique case (state_q)
      S_FETCH: begin
        busy = 1'b0;
        // rst forces FETCH asynchronously; keep ir_load quiet meanwhile
        ir_load = instr_valid & ~rst;
        if (instr_valid) begin
          instr_d = instruction;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        c_d     = c;
        z_d     = z;
        state_d = is_legal ? S_EXEC : S_FAULT;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        unique case (1'b1)
          is_reg, is_imm: begin
            pc_write                = 1'b1;
            sel_PCSrc_plus1         = 1'b1;
            ALU_op                  = {1'b0, instr_q[3:1]};
            sel_ALUScr_reg          = is_reg;
            sel_ALUScr_const        = is_imm;
            RegisterFileWriteEn     = 1'b1;
            sel_RegisterFile_in_alu = 1'b1;
            sel_Cin_alu             = 1'b1;
          end
          is_shift: begin
            pc_write                    = 1'b1;
            sel_PCSrc_plus1             = 1'b1;
            RegisterFileWriteEn         = 1'b1;
            sel_RegisterFile_in_shifter = 1'b1;
            sel_Cin_shifter             = 1'b1;
          end
          is_ldm, is_stm: begin
            ALU_op           = ADD_SIGNED;
            sel_ALUScr_const = 1'b1;
            state_d          = S_MEM;
          end
          is_bcond: begin
            pc_write         = 1'b1;
            sel_PCSrc_offset = taken;
            sel_PCSrc_plus1  = ~taken;
          end
          is_jsb: begin
            if (stack_count_q == CNT_FULL) begin
              state_d = S_FAULT;
            end else begin
              pc_write        = 1'b1;
              sel_PCSrc_const = 1'b1;
              push_stack      = 1'b1;
              stack_count_d   = stack_count_q + 1'b1;
            end
          end
          is_jmp: begin
            pc_write        = 1'b1;
            sel_PCSrc_const = 1'b1;
          end
          is_ret: begin
            if (stack_count_q == '0) begin
              state_d = S_FAULT;
            end else begin
              pc_write        = 1'b1;
              sel_PCSrc_stack = 1'b1;
              pop_stack       = 1'b1;
              stack_count_d   = stack_count_q - 1'b1;
            end
          end
          default: state_d = S_FAULT;
        endcase
      end
      S_MEM: begin
        ALU_op                      = ADD_SIGNED;
        sel_ALUScr_const            = 1'b1;
        MemRead                     = is_ldm;
        MemWrite                    = is_stm;
        sel_RegisterFileReadReg2_rd = is_stm;
        if (mem_ready) begin
          tmo_d = '0;
          if (is_stm) begin
            // STM retires in its last MEM cycle to keep 3+N latency
            pc_write        = 1'b1;
            sel_PCSrc_plus1 = 1'b1;
            state_d         = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WB: begin
        pc_write                   = 1'b1;
        sel_PCSrc_plus1            = 1'b1;
        RegisterFileWriteEn        = 1'b1;
        sel_RegisterFile_in_memory = 1'b1;
        state_d                    = S_FETCH;
      end
      S_FAULT: begin
        busy  = 1'b0;
        fault = 1'b1;
      end
      default: state_d = S_FAULT;
    endcase
  end

  assign stack_count = stack_count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller.
// Inputs driven on negedge, outputs sampled 1ns later.
module tb_multicycle_controller;

  localparam int CW = 4;

  localparam logic [5:0] OP_ADD = 6'b000010;
  localparam logic [5:0] OP_IMM = 6'b010110;
  localparam logic [5:0] OP_SHF = 6'b100001;
  localparam logic [5:0] OP_LDM = 6'b100100;
  localparam logic [5:0] OP_STM = 6'b100101;
  localparam logic [5:0] OP_BZ  = 6'b101000;
  localparam logic [5:0] OP_BNC = 6'b101011;
  localparam logic [5:0] OP_JMP = 6'b101100;
  localparam logic [5:0] OP_JSB = 6'b101101;
  localparam logic [5:0] OP_RET = 6'b110000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  localparam logic [19:0] M_IR    = 20'h80000;
  localparam logic [19:0] M_PCW   = 20'h40000;
  localparam logic [19:0] M_AREG  = 20'h20000;
  localparam logic [19:0] M_ACON  = 20'h10000;
  localparam logic [19:0] M_P1    = 20'h08000;
  localparam logic [19:0] M_POFF  = 20'h04000;
  localparam logic [19:0] M_PCON  = 20'h02000;
  localparam logic [19:0] M_PSTK  = 20'h01000;
  localparam logic [19:0] M_MR    = 20'h00800;
  localparam logic [19:0] M_MW    = 20'h00400;
  localparam logic [19:0] M_RFWE  = 20'h00200;
  localparam logic [19:0] M_WALU  = 20'h00100;
  localparam logic [19:0] M_WMEM  = 20'h00080;
  localparam logic [19:0] M_WSH   = 20'h00040;
  localparam logic [19:0] M_RD2   = 20'h00020;
  localparam logic [19:0] M_CALU  = 20'h00010;
  localparam logic [19:0] M_CSH   = 20'h00008;
  localparam logic [19:0] M_PUSH  = 20'h00004;
  localparam logic [19:0] M_POP   = 20'h00002;
  localparam logic [19:0] M_BUSY  = 20'h00001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic instr_valid = 1'b0;
  logic [5:0] instruction = '0;
  logic c = 1'b0, z = 1'b0, mem_ready = 1'b0;

  logic ir_load, pc_write;
  logic [3:0] ALU_op;
  logic sel_ALUScr_reg, sel_ALUScr_const;
  logic sel_PCSrc_plus1, sel_PCSrc_offset;
  logic sel_PCSrc_const, sel_PCSrc_stack;
  logic MemRead, MemWrite, RegisterFileWriteEn;
  logic sel_RegisterFile_in_alu, sel_RegisterFile_in_memory;
  logic sel_RegisterFile_in_shifter, sel_RegisterFileReadReg2_rd;
  logic sel_Cin_alu, sel_Cin_shifter;
  logic push_stack, pop_stack;
  logic [CW-1:0] stack_count;
  logic fault, busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multicycle_controller #(
    .STACK_DEPTH(8), .MEM_TIMEOUT(15), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instruction(instruction),
    .c(c), .z(z), .mem_ready(mem_ready),
    .ir_load(ir_load), .pc_write(pc_write), .ALU_op(ALU_op),
    .sel_ALUScr_reg(sel_ALUScr_reg),
    .sel_ALUScr_const(sel_ALUScr_const),
    .sel_PCSrc_plus1(sel_PCSrc_plus1),
    .sel_PCSrc_offset(sel_PCSrc_offset),
    .sel_PCSrc_const(sel_PCSrc_const),
    .sel_PCSrc_stack(sel_PCSrc_stack),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .RegisterFileWriteEn(RegisterFileWriteEn),
    .sel_RegisterFile_in_alu(sel_RegisterFile_in_alu),
    .sel_RegisterFile_in_memory(sel_RegisterFile_in_memory),
    .sel_RegisterFile_in_shifter(sel_RegisterFile_in_shifter),
    .sel_RegisterFileReadReg2_rd(sel_RegisterFileReadReg2_rd),
    .sel_Cin_alu(sel_Cin_alu), .sel_Cin_shifter(sel_Cin_shifter),
    .push_stack(push_stack), .pop_stack(pop_stack),
    .stack_count(stack_count), .fault(fault), .busy(busy)
  );

  wire [19:0] outs = {
    ir_load, pc_write, sel_ALUScr_reg, sel_ALUScr_const,
    sel_PCSrc_plus1, sel_PCSrc_offset, sel_PCSrc_const,
    sel_PCSrc_stack, MemRead, MemWrite, RegisterFileWriteEn,
    sel_RegisterFile_in_alu, sel_RegisterFile_in_memory,
    sel_RegisterFile_in_shifter, sel_RegisterFileReadReg2_rd,
    sel_Cin_alu, sel_Cin_shifter, push_stack, pop_stack, busy
  };

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    instr_valid = 1'b1;
    instruction = OP_ADD;
    mem_ready = 1'b0;
    #1;
    check("rst_outs", 32'(outs), 32'h0);
    check("rst_aluop", 32'(ALU_op), 32'h0);
    check("rst_cnt", 32'(stack_count), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    instr_valid = 1'b0;
  endtask

  // Fetch + decode; returns positioned in the EXEC cycle.
  task automatic fetch_decode(input logic [5:0] op,
                              input logic cv, input logic zv);
    @(negedge clk);
    instr_valid = 1'b1;
    instruction = op;
    #1;
    check("fetch", 32'(outs), 32'(M_IR));
    @(negedge clk);
    instr_valid = 1'b0;
    instruction = 6'b0;
    c = cv;
    z = zv;
    #1;
    check("decode", 32'(outs), 32'(M_BUSY));
    step();
  endtask

  initial begin
    int cnt;

    do_reset();

    // ADD: EXEC at cycle 2, back in FETCH at 3
    fetch_decode(OP_ADD, 1'b0, 1'b0);
    check("add_exec", 32'(outs), 32'(M_PCW | M_P1 | M_AREG
          | M_RFWE | M_WALU | M_CALU | M_BUSY));
    check("add_aluop", 32'(ALU_op), 32'h1);
    step();
    check("add_done", 32'(outs), 32'h0);

    fetch_decode(OP_IMM, 1'b0, 1'b0);
    check("imm_exec", 32'(outs), 32'(M_PCW | M_P1 | M_ACON
          | M_RFWE | M_WALU | M_CALU | M_BUSY));
    check("imm_aluop", 32'(ALU_op), 32'h3);

    fetch_decode(OP_SHF, 1'b0, 1'b0);
    check("shf_exec", 32'(outs), 32'(M_PCW | M_P1 | M_RFWE
          | M_WSH | M_CSH | M_BUSY));

    fetch_decode(OP_JMP, 1'b0, 1'b0);
    check("jmp_exec", 32'(outs), 32'(M_PCW | M_PCON | M_BUSY));

    // BZ: z latched at DECODE, live z dropped during EXEC
    fetch_decode(OP_BZ, 1'b0, 1'b1);
    z = 1'b0;
    #1;
    check("bz_exec", 32'(outs), 32'(M_PCW | M_POFF | M_BUSY));
    fetch_decode(OP_BNC, 1'b1, 1'b0);
    check("bnc_exec", 32'(outs), 32'(M_PCW | M_P1 | M_BUSY));
    c = 1'b0;

    // LDM, mem_ready on 3rd MEM cycle
    fetch_decode(OP_LDM, 1'b0, 1'b0);
    check("ldm_exec", 32'(outs), 32'(M_ACON | M_BUSY));
    check("ldm_aluop", 32'(ALU_op), 32'h8);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = (i == 2);
      #1;
      cnt += int'(MemRead);
      check("ldm_mem", 32'(outs), 32'(M_MR | M_ACON | M_BUSY));
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("ldm_mr_cnt", 32'(cnt), 32'd3);
    check("ldm_wb", 32'(outs), 32'(M_PCW | M_P1 | M_RFWE
          | M_WMEM | M_BUSY));
    step();
    check("ldm_done", 32'(outs), 32'h0);

    // STM succeeding on first MEM cycle retires that cycle
    fetch_decode(OP_STM, 1'b0, 1'b0);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("stm_ok", 32'(outs), 32'(M_MW | M_RD2 | M_ACON
          | M_PCW | M_P1 | M_BUSY));
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("stm_done", 32'(outs), 32'h0);

    // JSB then RET
    fetch_decode(OP_JSB, 1'b0, 1'b0);
    check("jsb_exec", 32'(outs), 32'(M_PCW | M_PCON
          | M_PUSH | M_BUSY));
    step();
    check("jsb_cnt", 32'(stack_count), 32'd1);
    fetch_decode(OP_RET, 1'b0, 1'b0);
    check("ret_exec", 32'(outs), 32'(M_PCW | M_PSTK
          | M_POP | M_BUSY));
    step();
    check("ret_cnt", 32'(stack_count), 32'd0);

    // Nine JSBs: eight push, ninth faults
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      fetch_decode(OP_JSB, 1'b0, 1'b0);
      cnt += int'(push_stack);
    end
    check("push_cnt", 32'(cnt), 32'd8);
    step();
    check("stack_full", 32'(stack_count), 32'd8);
    fetch_decode(OP_JSB, 1'b0, 1'b0);
    check("jsb_ovf", 32'(outs), 32'(M_BUSY));
    step();
    check("ovf_fault", 32'(fault), 32'd1);
    check("ovf_cnt", 32'(stack_count), 32'd8);

    do_reset();
    fetch_decode(OP_RET, 1'b0, 1'b0);
    check("ret_unf", 32'(outs), 32'(M_BUSY));
    step();
    check("unf_fault", 32'(fault), 32'd1);
    check("unf_cnt", 32'(stack_count), 32'd0);

    // STM timeout
    do_reset();
    fetch_decode(OP_STM, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      cnt += int'(MemWrite);
    end
    check("stm_mw_cnt", 32'(cnt), 32'd15);
    check("tmo_fault", 32'(fault), 32'd1);
    @(negedge clk);
    instr_valid = 1'b1;
    #1;
    check("fault_outs", 32'(outs), 32'h0);
    instr_valid = 1'b0;

    // Illegal opcode
    do_reset();
    fetch_decode(OP_BAD, 1'b0, 1'b0);
    check("bad_fault", 32'(fault), 32'd1);
    check("bad_outs", 32'(outs), 32'h0);

    // Reset during MEM of LDM, then a clean ADD
    do_reset();
    fetch_decode(OP_LDM, 1'b0, 1'b0);
    step();
    check("mid_mem", 32'(outs), 32'(M_MR | M_ACON | M_BUSY));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_outs", 32'(outs), 32'h0);
    check("mid_rst_cnt", 32'(stack_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fetch_decode(OP_ADD, 1'b0, 1'b0);
    check("post_add", 32'(outs), 32'(M_PCW | M_P1 | M_AREG
          | M_RFWE | M_WALU | M_CALU | M_BUSY));
    check("post_fault", 32'(fault), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
